// File: rtl/irq_latch_83.sv
// rtl/irq_latch_83.sv - request synchroniser, pending latch and single-level service FSM feeding coder_83
module irq_latch_83 #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_in,
    input  logic [7:0] mask,
    input  logic       ack,
    input  logic [2:0] ack_code,
    input  logic       eoi,
    output logic [7:0] pend_out,
    output logic       irq,
    output logic       busy,
    output logic [2:0] isr_code,
    output logic       err
);

    typedef enum logic {IDLE, SERVICE} state_t;

    state_t     state;
    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] prev;
    logic [7:0] pending;
    logic [7:0] sr;
    logic [7:0] detect;
    logic [7:0] clr_vec;
    logic       ack_hit;
    logic       accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'h00;
        end else begin
            sync_q[0] <= req_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sr     = sync_q[SYNC_STAGES-1];
    assign detect = EDGE_MODE ? (sr & ~prev) : sr;

    // pending stays latched while hidden; only the IDLE view reaches the encoder
    assign pend_out = (state == IDLE) ? (pending & ~mask) : 8'h00;
    assign irq      = |pend_out;
    assign busy     = (state == SERVICE);

    assign ack_hit = pend_out[ack_code];
    assign accept  = (state == IDLE) && ack && ack_hit;
    assign clr_vec = accept ? (8'd1 << ack_code) : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prev     <= 8'h00;
            pending  <= 8'h00;
            isr_code <= 3'd0;
            err      <= 1'b0;
        end else begin
            prev    <= sr;
            // a detect on the acknowledged bit wins: it is a fresh request
            pending <= (pending & ~clr_vec) | detect;
            err     <= (state == IDLE) && ack && !ack_hit;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= SERVICE;
                        isr_code <= ack_code;
                    end
                end
                SERVICE: begin
                    if (eoi) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_latch_83.sv
// tb/tb_irq_latch_83.sv - randomized and directed bench for irq_latch_83 against a delay-line reference model
module tb_irq_latch_83;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_in, mask;
    logic       ack, eoi;
    logic [2:0] ack_code;
    logic [7:0] pend_out;
    logic       irq, busy, err;
    logic [2:0] isr_code;

    int total = 0;
    int bad   = 0;

    irq_latch_83 #(.SYNC_STAGES(S), .EDGE_MODE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .ack(ack),
        .ack_code(ack_code), .eoi(eoi), .pend_out(pend_out), .irq(irq),
        .busy(busy), .isr_code(isr_code), .err(err)
    );

    always #5 clk = ~clk;

    // reference state: request samples seen at each edge, oldest first
    logic [7:0] hist [$];
    logic [7:0] m_prev, m_pend;
    logic       m_busy, m_err;
    logic [2:0] m_isr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < S; i++) hist.push_back(8'h00);
        m_prev = 8'h00; m_pend = 8'h00; m_busy = 1'b0; m_err = 1'b0; m_isr = 3'd0;
    endtask

    function automatic logic [7:0] m_vis(input logic [7:0] msk);
        return m_busy ? 8'h00 : (m_pend & ~msk);
    endfunction

    task automatic model_edge();
        logic [7:0] sr, vis, det;
        sr  = hist[0];
        det = sr & ~m_prev;
        vis = m_vis(mask);
        m_err = !m_busy && ack && !vis[ack_code];
        if (!m_busy && ack && vis[ack_code]) begin
            m_pend[ack_code] = 1'b0;
            m_isr  = ack_code;
            m_busy = 1'b1;
        end else if (m_busy && eoi) begin
            m_busy = 1'b0;
        end
        m_pend = m_pend | det;
        m_prev = sr;
        void'(hist.pop_front());
        hist.push_back(req_in);
    endtask

    task automatic compare_all();
        check("pend_out", 32'(pend_out), 32'(m_vis(mask)));
        check("irq", 32'(irq), 32'(|m_vis(mask)));
        check("busy", 32'(busy), 32'(m_busy));
        check("isr_code", 32'(isr_code), 32'(m_isr));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic step(input logic [7:0] r, input logic [7:0] m, input logic a,
                        input logic [2:0] c, input logic e);
        req_in = r; mask = m; ack = a; ack_code = c; eoi = e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n, input logic [7:0] m);
        for (int i = 0; i < n; i++) step(8'h00, m, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        logic [7:0] vis;
        rst_n = 1'b0; req_in = 8'h00; mask = 8'h00; ack = 1'b0; ack_code = 3'd0; eoi = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_pend", 32'(pend_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;

        // capture latency: raised before edge 1, visible after edge 3
        step(8'h20, 8'h00, 0, 0, 0);
        step(8'h00, 8'h00, 0, 0, 0);
        check("t1_not_yet", 32'(pend_out), 32'h00);
        step(8'h00, 8'h00, 0, 0, 0);
        check("t1_pend", 32'(pend_out), 32'h20);
        check("t1_irq", 32'(irq), 32'h1);
        step(8'h00, 8'h00, 1, 3'd5, 0);
        step(8'h00, 8'h00, 0, 0, 1);

        // service of the higher-priority bit hides the other until eoi
        step(8'h82, 8'h00, 0, 0, 0);
        idle(2, 8'h00);
        step(8'h00, 8'h00, 1, 3'd7, 0);
        check("t2_busy", 32'(busy), 32'h1);
        check("t2_isr", 32'(isr_code), 32'h7);
        check("t2_hidden", 32'(pend_out), 32'h00);
        step(8'h00, 8'h00, 1, 3'd1, 0);
        check("t2_ack_ign_err", 32'(err), 32'h0);
        step(8'h00, 8'h00, 0, 0, 1);
        check("t2_after_eoi", 32'(pend_out), 32'h02);
        check("t2_isr_hold", 32'(isr_code), 32'h7);
        step(8'h00, 8'h00, 1, 3'd1, 0);
        step(8'h00, 8'h00, 0, 0, 1);

        // masking hides but keeps; unmasking exposes without a clock
        step(8'h08, 8'hFF, 0, 0, 0);
        idle(3, 8'hFF);
        check("t3_masked", 32'(pend_out), 32'h00);
        check("t3_masked_irq", 32'(irq), 32'h0);
        mask = 8'h00;
        #1;
        check("t3_unmask", 32'(pend_out), 32'h08);
        step(8'h00, 8'h00, 1, 3'd3, 0);
        step(8'h00, 8'h00, 0, 0, 1);

        // ack of a code that is not pending
        step(8'h01, 8'h00, 0, 0, 0);
        idle(2, 8'h00);
        step(8'h00, 8'h00, 1, 3'd4, 0);
        check("t4_err", 32'(err), 32'h1);
        check("t4_busy", 32'(busy), 32'h0);
        step(8'h00, 8'h00, 0, 0, 0);
        check("t4_err_pulse", 32'(err), 32'h0);
        step(8'h00, 8'h00, 1, 3'd0, 0);
        step(8'h00, 8'h00, 0, 0, 1);
        step(8'h00, 8'h00, 1, 3'd2, 0);
        check("t4_idle_ack", 32'(err), 32'h1);

        // new edge on bit 1 lands in the same cycle it is acknowledged
        step(8'h02, 8'h00, 0, 0, 0);
        step(8'h00, 8'h00, 0, 0, 0);
        step(8'h02, 8'h00, 0, 0, 0);
        step(8'h00, 8'h00, 0, 0, 0);
        step(8'h00, 8'h00, 1, 3'd1, 0);
        check("t5_busy", 32'(busy), 32'h1);
        step(8'h00, 8'h00, 0, 0, 1);
        check("t5_set_wins", 32'(pend_out), 32'h02);
        step(8'h00, 8'h00, 1, 3'd1, 0);
        step(8'h00, 8'h00, 0, 0, 1);

        // asynchronous reset in SERVICE with hidden requests
        step(8'h01, 8'h00, 0, 0, 0);
        idle(2, 8'h00);
        step(8'h00, 8'h00, 1, 3'd0, 0);
        step(8'h0C, 8'h00, 0, 0, 0);
        idle(3, 8'h00);
        check("t6_busy_pre", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_pend", 32'(pend_out), 32'h00);
        check("t6_irq", 32'(irq), 32'h0);
        check("t6_isr", 32'(isr_code), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2, 8'h00);
        check("t6_lost", 32'(pend_out), 32'h00);

        // randomized traffic, acks mostly aimed at a visible bit
        for (int n = 0; n < 800; n++) begin
            logic [7:0] r, m;
            logic       a, e;
            logic [2:0] c;
            r = 8'($urandom) & 8'($urandom);
            m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            a = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 3) == 0);
            c = 3'($urandom);
            vis = m_vis(m);
            if (vis != 8'h00 && $urandom_range(0, 3) != 0) begin
                for (int b = 0; b < 8; b++) if (vis[b]) c = 3'(b);
            end
            step(r, m, a, c, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
